// File: rtl/branch_resolver.sv
// branch_resolver: buffers completed branches, issues one oldest-first resolution per cycle and squashes on mispredict.
module branch_resolver #(
  parameter int B_MASK_WIDTH = 4,
  parameter int NUM_BR_FU    = 2,
  parameter int BUF_DEPTH    = 4
) (
  input  logic                                     clock,
  input  logic                                     reset,
  input  logic [NUM_BR_FU-1:0]                     ex_valid,
  input  logic [NUM_BR_FU-1:0][B_MASK_WIDTH-1:0]   ex_self_bit,
  input  logic [NUM_BR_FU-1:0][B_MASK_WIDTH-1:0]   ex_dep_mask,
  input  logic [NUM_BR_FU-1:0]                     ex_taken,
  input  logic [NUM_BR_FU-1:0][31:0]               ex_target,
  input  logic [NUM_BR_FU-1:0]                     ex_pred_taken,
  input  logic [NUM_BR_FU-1:0][31:0]               ex_pred_target,
  output logic                                     br_ready,
  output logic [B_MASK_WIDTH-1:0]                  b_mm_resolve,
  output logic                                     b_mm_mispred
);
  typedef logic [B_MASK_WIDTH-1:0] mask_t;
  logic [BUF_DEPTH-1:0] vld, vld_n, sel, mis_q, mis_n;
  mask_t self_q [BUF_DEPTH];
  mask_t dep_q  [BUF_DEPTH];
  mask_t self_n [BUF_DEPTH];
  mask_t dep_n  [BUF_DEPTH];
  mask_t pend, s_bit, sq, clr;
  logic s_mis, placed;
  logic [NUM_BR_FU-1:0] in_mis;
  int cnt;
  always_comb begin
    pend = '0;
    cnt = 0;
    for (int i = 0; i < BUF_DEPTH; i++) begin
      pend |= vld[i] ? self_q[i] : '0;
      cnt += vld[i] ? 1 : 0;
    end
    sel = '0;
    s_bit = '0;
    s_mis = 1'b0;
    for (int i = 0; i < BUF_DEPTH; i++)
      if (vld[i] && (dep_q[i] & pend) == '0 && sel == '0) begin
        sel[i] = 1'b1;
        s_bit = self_q[i];
        s_mis = mis_q[i];
      end
    // S is the branch issuing at this edge, C the one already on the outputs
    sq  = (s_mis ? s_bit : '0) | (b_mm_mispred ? b_mm_resolve : '0);
    clr = (s_mis ? '0 : s_bit) | (b_mm_mispred ? '0 : b_mm_resolve);
    for (int i = 0; i < BUF_DEPTH; i++) begin
      vld_n[i]  = vld[i] && !sel[i] && (dep_q[i] & sq) == '0;
      self_n[i] = self_q[i];
      dep_n[i]  = dep_q[i] & ~clr;
      mis_n[i]  = mis_q[i];
    end
    placed = 1'b0;
    for (int f = 0; f < NUM_BR_FU; f++) begin
      in_mis[f] = (ex_taken[f] != ex_pred_taken[f]) || (ex_taken[f] && ex_target[f] != ex_pred_target[f]);
      placed = 1'b0;
      if (ex_valid[f] && (ex_dep_mask[f] & sq) == '0)
        for (int j = 0; j < BUF_DEPTH; j++)
          if (!placed && !vld_n[j]) begin
            vld_n[j]  = 1'b1;
            self_n[j] = ex_self_bit[f];
            dep_n[j]  = ex_dep_mask[f] & ~clr;
            mis_n[j]  = in_mis[f];
            placed    = 1'b1;
          end
    end
  end
  assign br_ready = cnt + NUM_BR_FU <= BUF_DEPTH;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld          <= '0;
      b_mm_resolve <= '0;
      b_mm_mispred <= 1'b0;
    end else begin
      vld          <= vld_n;
      b_mm_resolve <= s_bit;
      b_mm_mispred <= s_mis;
    end
  end
  always_ff @(posedge clock) begin
    self_q <= self_n;
    dep_q  <= dep_n;
    mis_q  <= mis_n;
  end
  a_mispred_needs_resolve: assert property (@(posedge clock) disable iff (reset) b_mm_mispred |-> b_mm_resolve != '0);
  for (genvar f = 0; f < NUM_BR_FU; f++) begin : g_chk
    a_ready:  assert property (@(posedge clock) disable iff (reset) ex_valid[f] |-> br_ready);
    a_onehot: assert property (@(posedge clock) disable iff (reset) ex_valid[f] |-> $onehot(ex_self_bit[f]));
    a_dup:    assert property (@(posedge clock) disable iff (reset) ex_valid[f] |-> (ex_self_bit[f] & pend) == '0);
    for (genvar j = f + 1; j < NUM_BR_FU; j++) begin : g_pair
      a_dup_in: assert property (@(posedge clock) disable iff (reset)
        (ex_valid[f] && ex_valid[j]) |-> (ex_self_bit[f] & ex_self_bit[j]) == '0);
    end
  end
endmodule

// File: tb/tb_branch_resolver.sv
// tb_branch_resolver: directed tests of branch_resolver issue order, mispredict squash and flow control.
module tb_branch_resolver;
  logic clock = 1'b0, reset = 1'b1;
  logic [1:0] ex_valid, ex_taken, ex_pred_taken;
  logic [1:0][3:0] ex_self_bit, ex_dep_mask;
  logic [1:0][31:0] ex_target, ex_pred_target;
  logic br_ready, b_mm_mispred;
  logic [3:0] b_mm_resolve;
  logic [5:0] obs;
  int n = 0, fails = 0;
  assign obs = {br_ready, b_mm_resolve, b_mm_mispred};
  branch_resolver dut (
    .clock(clock), .reset(reset), .ex_valid(ex_valid), .ex_self_bit(ex_self_bit),
    .ex_dep_mask(ex_dep_mask), .ex_taken(ex_taken), .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .br_ready(br_ready), .b_mm_resolve(b_mm_resolve), .b_mm_mispred(b_mm_mispred));
  always #5 clock = ~clock;
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  task automatic clear_in;
    ex_valid = '0; ex_taken = '0; ex_pred_taken = '0;
    ex_self_bit = '0; ex_dep_mask = '0; ex_target = '0; ex_pred_target = '0;
  endtask
  task automatic drive(input int f, input logic [3:0] s, input logic [3:0] d, input logic t,
                       input logic pt, input logic [31:0] tg, input logic [31:0] ptg);
    ex_valid[f] = 1'b1; ex_self_bit[f] = s; ex_dep_mask[f] = d;
    ex_taken[f] = t; ex_pred_taken[f] = pt; ex_target[f] = tg; ex_pred_target[f] = ptg;
  endtask
  // obs = {br_ready, b_mm_resolve[3:0], b_mm_mispred}
  task automatic test_reset;
    clear_in();
    tick(); tick();
    #2 reset = 1'b0;
    tick();
    n++; if (obs !== 6'b1_0000_0) begin fails++; $display("FAIL reset_init got=%b exp=%b", obs, 6'b1_0000_0); end
    drive(0, 4'b0001, 4'b0000, 1'b1, 1'b1, 32'h10, 32'h10);
    drive(1, 4'b0010, 4'b0001, 1'b1, 1'b1, 32'h20, 32'h20);
    tick(); clear_in();
    drive(0, 4'b0100, 4'b0010, 1'b1, 1'b1, 32'h30, 32'h30);
    drive(1, 4'b1000, 4'b0010, 1'b1, 1'b1, 32'h40, 32'h40);
    tick(); clear_in();
    n++; if (obs !== 6'b0_0001_0) begin fails++; $display("FAIL reset_loaded got=%b exp=%b", obs, 6'b0_0001_0); end
    #2 reset = 1'b1;
    #1;
    n++; if (obs !== 6'b1_0000_0) begin fails++; $display("FAIL reset_async got=%b exp=%b", obs, 6'b1_0000_0); end
    tick();
    #2 reset = 1'b0;
    tick();
    n++; if (obs !== 6'b1_0000_0) begin fails++; $display("FAIL reset_cleared got=%b exp=%b", obs, 6'b1_0000_0); end
  endtask
  task automatic test_single;
    drive(0, 4'b0010, 4'b0000, 1'b1, 1'b1, 32'h80, 32'h80);
    tick(); clear_in();
    n++; if (obs !== 6'b1_0000_0) begin fails++; $display("FAIL single_e0 got=%b exp=%b", obs, 6'b1_0000_0); end
    tick();
    n++; if (obs !== 6'b1_0010_0) begin fails++; $display("FAIL single_e1 got=%b exp=%b", obs, 6'b1_0010_0); end
    tick();
    n++; if (obs !== 6'b1_0000_0) begin fails++; $display("FAIL single_e2 got=%b exp=%b", obs, 6'b1_0000_0); end
  endtask
  task automatic test_pair;
    drive(0, 4'b0001, 4'b0000, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 4'b0100, 4'b0001, 1'b1, 1'b1, 32'h44, 32'h44);
    tick(); clear_in();
    tick();
    n++; if (obs !== 6'b1_0001_0) begin fails++; $display("FAIL pair_first got=%b exp=%b", obs, 6'b1_0001_0); end
    tick();
    n++; if (obs !== 6'b1_0100_0) begin fails++; $display("FAIL pair_second got=%b exp=%b", obs, 6'b1_0100_0); end
    tick();
    n++; if (obs !== 6'b1_0000_0) begin fails++; $display("FAIL pair_idle got=%b exp=%b", obs, 6'b1_0000_0); end
  endtask
  task automatic test_mispred;
    drive(0, 4'b0001, 4'b0000, 1'b1, 1'b0, 32'h100, 32'h100);
    drive(1, 4'b0100, 4'b0001, 1'b1, 1'b1, 32'h44, 32'h44);
    tick(); clear_in();
    tick();
    n++; if (obs !== 6'b1_0001_1) begin fails++; $display("FAIL mis_issue got=%b exp=%b", obs, 6'b1_0001_1); end
    drive(0, 4'b0010, 4'b0001, 1'b0, 1'b0, 32'h0, 32'h0);
    tick(); clear_in();
    n++; if (obs !== 6'b1_0000_0) begin fails++; $display("FAIL mis_squash_buf got=%b exp=%b", obs, 6'b1_0000_0); end
    tick();
    n++; if (obs !== 6'b1_0000_0) begin fails++; $display("FAIL mis_squash_in got=%b exp=%b", obs, 6'b1_0000_0); end
  endtask
  task automatic test_target;
    drive(0, 4'b1000, 4'b0000, 1'b1, 1'b1, 32'h100, 32'h200);
    drive(1, 4'b0001, 4'b0000, 1'b0, 1'b0, 32'h300, 32'h400);
    tick(); clear_in();
    tick();
    n++; if (obs !== 6'b1_1000_1) begin fails++; $display("FAIL tgt_mismatch got=%b exp=%b", obs, 6'b1_1000_1); end
    tick();
    n++; if (obs !== 6'b1_0001_0) begin fails++; $display("FAIL tgt_not_taken got=%b exp=%b", obs, 6'b1_0001_0); end
    tick();
    n++; if (obs !== 6'b1_0000_0) begin fails++; $display("FAIL tgt_idle got=%b exp=%b", obs, 6'b1_0000_0); end
  endtask
  task automatic test_back_to_back;
    drive(0, 4'b0001, 4'b0000, 1'b1, 1'b1, 32'h10, 32'h10);
    drive(1, 4'b0010, 4'b0001, 1'b1, 1'b1, 32'h20, 32'h20);
    tick(); clear_in();
    n++; if (obs !== 6'b1_0000_0) begin fails++; $display("FAIL chain_load1 got=%b exp=%b", obs, 6'b1_0000_0); end
    drive(0, 4'b0100, 4'b0011, 1'b1, 1'b1, 32'h30, 32'h30);
    drive(1, 4'b1000, 4'b0111, 1'b1, 1'b1, 32'h40, 32'h40);
    tick(); clear_in();
    n++; if (obs !== 6'b0_0001_0) begin fails++; $display("FAIL chain_r0 got=%b exp=%b", obs, 6'b0_0001_0); end
    tick();
    n++; if (obs !== 6'b1_0010_0) begin fails++; $display("FAIL chain_r1 got=%b exp=%b", obs, 6'b1_0010_0); end
    tick();
    n++; if (obs !== 6'b1_0100_0) begin fails++; $display("FAIL chain_r2 got=%b exp=%b", obs, 6'b1_0100_0); end
    tick();
    n++; if (obs !== 6'b1_1000_0) begin fails++; $display("FAIL chain_r3 got=%b exp=%b", obs, 6'b1_1000_0); end
    tick();
    n++; if (obs !== 6'b1_0000_0) begin fails++; $display("FAIL chain_idle got=%b exp=%b", obs, 6'b1_0000_0); end
  endtask
  initial begin
    test_reset();
    test_single();
    test_pair();
    test_mispred();
    test_target();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n, fails);
    $finish;
  end
endmodule
